// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

   localparam int CNT_W       = 3;
   localparam int MAX_LATENCY = (1 << CNT_W) - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM with a registered read port. Storage is not reset;
// only the read register returns to zero.
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              unused_addr;

   // Upper address bits are range-checked by the responder before en is raised.
   assign idx         = addr[IDX_W-1:0];
   assign unused_addr = ^addr;

   // Storage write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= din;
      end
   end

   // Read register only changes on an enabled read, so it holds the last read value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout <= '0;
      end else if (en && !we) begin
         dout <= mem[idx];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side handshake for the multicycle control unit: accepts a held
// MemRead/MemWrite request, waits LATENCY cycles, performs one word access and
// acknowledges with a single-cycle mem_ready.
module mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_ready,
   output logic              mem_busy,
   output logic              err
);

   import mem_resp_pkg::*;

   if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_latency_check
      $error("mem_responder: LATENCY must be in 0..7");
   end

   if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
      $error("mem_responder: DEPTH must be in 2..2**ADDR_W");
   end

   localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(LATENCY);
   localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   op_t               op_q;
   logic              err_q;

   logic              req_any;
   logic              req_one;
   logic              req_both;
   logic              access_fire;
   logic              acc_in_range;
   logic              acc_is_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              ram_en;
   logic              ram_we;
   logic              err_set;

   assign req_any  = mem_read | mem_write;
   assign req_one  = mem_read ^ mem_write;
   assign req_both = mem_read & mem_write;

   // Next state, plus the RAM strobe for the edge entering DONE. With zero latency
   // that edge leaves IDLE, so the live request fields are used instead of the latches.
   always_comb begin
      state_next   = state;
      access_fire  = 1'b0;
      acc_addr     = addr_q;
      acc_wdata    = wdata_q;
      acc_is_wr    = (op_q == OP_WR);
      err_set      = 1'b0;
      case (state)
         IDLE: begin
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_is_wr = mem_write;
            if (req_both) begin
               state_next = RELEASE;
               err_set    = 1'b1;
            end else if (req_one) begin
               if (LATENCY == 0) begin
                  state_next  = DONE;
                  access_fire = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (!req_any) begin
               state_next = IDLE;
            end else if (cnt == CNT_W'(1)) begin
               state_next  = DONE;
               access_fire = 1'b1;
            end
         end
         DONE: begin
            state_next = req_any ? RELEASE : IDLE;
         end
         RELEASE: begin
            if (!req_any) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);
      ram_en       = access_fire && acc_in_range;
      ram_we       = acc_is_wr;
      if (access_fire && !acc_in_range) begin
         err_set = 1'b1;
      end
   end

   // State register, wait counter and the one-cycle error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_next;
         err_q <= err_set;
         if (state == IDLE && req_one) begin
            cnt <= LAT_CNT;
         end else if (state == WAIT && req_any && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Capture the request once at acceptance so later input changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= OP_RD;
      end else if (state == IDLE && req_one) begin
         addr_q  <= addr;
         wdata_q <= wdata;
         op_q    <= mem_write ? OP_WR : OP_RD;
      end
   end

   assign mem_ready = (state == DONE);
   assign mem_busy  = (state == WAIT) || (state == DONE);
   assign err       = err_q;

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem_array (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ram_en),
      .we      (ram_we),
      .addr    (acc_addr),
      .din     (acc_wdata),
      .dout    (rdata)
   );

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the multicycle processor. It is the memory-side end of the control unit's `MemRead`/`MemWrite` interface: it accepts a level-held request issued during the MEM state, runs a configurable number of wait cycles, performs a single-port word access, and returns a one-cycle `mem_ready` acknowledge with read data. It sits between the control unit/datapath and the data RAM and gives the control FSM a real handshake in place of a fixed one-cycle MEM assumption.

## Interface
- `ADDR_W`, 8: word-address width.
- `DATA_W`, 16: data word width.
- `DEPTH`, 256: number of implemented words, ≤ 2^ADDR_W.
- `LATENCY`, 2: wait cycles before acknowledge, 0..7.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  read request, level, held until `mem_ready`.
- `mem_write`  in  1  write request, level, held until `mem_ready`.
- `addr`  in  ADDR_W  word address, stable while a request is held.
- `wdata`  in  DATA_W  write data, stable while `mem_write` is held.
- `rdata`  out  DATA_W  read data, registered, valid when `mem_ready` is high after a read.
- `mem_ready`  out  1  one-cycle acknowledge.
- `mem_busy`  out  1  high in WAIT and DONE.
- `err`  out  1  one-cycle error flag, coincident with `mem_ready` or issued alone (see below).

## Operation
- FSM states: IDLE, WAIT, DONE, RELEASE.
- **IDLE:**
  - Exactly one of `mem_read`/`mem_write` high: latch `addr`, `wdata` and op into `addr_q`, `wdata_q`, `op_q`. Load `cnt` = LATENCY. Go to WAIT, or to DONE if LATENCY = 0.
  - Both high: assert `err` for the next cycle. No access. Go to RELEASE.
  - Neither high: stay in IDLE.
- **WAIT:**
  - Request dropped (both low): abort to IDLE. No access, no `mem_ready`.
  - Otherwise decrement `cnt`. On the edge where `cnt` = 1, go to DONE.
- **Access on the edge entering DONE:**
  - Read: `rdata` ← mem[`addr_q`].
  - Write: mem[`addr_q`] ← `wdata_q`; `rdata` unchanged.
  - `addr_q` ≥ DEPTH: no access, `rdata` unchanged, `err` asserted together with `mem_ready`.
- **DONE:** `mem_ready` = 1 for exactly this cycle. Next state is IDLE if both requests are low, else RELEASE. A request still held is never re-served.
- **RELEASE:** wait until both requests are low, then go to IDLE. Outputs are low.
- `rdata` holds its last read value indefinitely.
- Memory contents are not initialized by reset.
- **Reset (async, any state, including mid-WAIT):**
  - State = IDLE, `cnt` = 0.
  - `rdata` = 0, `mem_ready` = 0, `mem_busy` = 0, `err` = 0.
  - An in-flight write is discarded. The RAM is not written.

## Timing
- Cycle numbering: the request is first sampled high at edge 0.
- `mem_ready` is high in the cycle after edge LATENCY, i.e. LATENCY+1 cycles after the request becomes visible.
- LATENCY = 0 gives `mem_ready` in the cycle immediately after edge 0.
- `mem_busy` rises after edge 0 and falls after the DONE cycle.
- Earliest back-to-back sequence: request high → DONE → request low for one cycle (IDLE) → new request sampled. Minimum per-access period is LATENCY+2 cycles.
- `cnt` is 3 bits. LATENCY values outside 0..7 are illegal and must be rejected by a parameter check at elaboration.
- `addr` and `wdata` changes after edge 0 are ignored, because the latched copies are used.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, DONE=2'd2, RELEASE=2'd3);
  - the op encoding (OP_RD=1'b0, OP_WR=1'b1);
  - the `cnt` width constant.
- Sub-module `mem_array`: synchronous single-port RAM (DEPTH × DATA_W) with `we`, `en`, `addr`, `din` and registered `dout`. The FSM drives `en` only on the DONE-entry edge.

## Test plan
- LATENCY=2: write 16'hBEEF to addr 8'h05, then read 8'h05 → `mem_ready` high 3 cycles after each request, `rdata` = 16'hBEEF, `err` = 0.
- LATENCY=0: read addr 8'h00 after a prior write of 16'h1234 → `mem_ready` in the next cycle, `rdata` = 16'h1234.
- `mem_read` and `mem_write` raised together at addr 8'h10 → `err` pulses once, no `mem_ready`, mem[8'h10] unchanged, FSM parks in RELEASE until both are low.
- Write request dropped after 1 of 3 wait cycles (LATENCY=3) → no `mem_ready`, FSM returns to IDLE, target word keeps its old value.
- `reset_n` pulled low mid-WAIT of a write of 16'hAAAA → all outputs 0 immediately. After release, a read of that address returns the pre-write value.
- DEPTH=128, read addr 8'hC0 → `mem_ready` and `err` high in the same cycle, `rdata` keeps its previous value.
